irq_controller: RTL and testbench
=================================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, meaning the number of interrupt source channels (range 1..16).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the width of the per-source data word delivered with an interrupt.
REQ-003 The block SHALL have parameter EDGE_MASK, default all ones (NUM_SRC bits), meaning a per-source trigger type: bit=1 is rising-edge, bit=0 is level.
REQ-004 The block SHALL have parameter RR_MODE, default 0, meaning arbitration mode: 0 is fixed priority with index 0 highest, 1 is round-robin.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, a synchronous active-low reset.
REQ-007 The block SHALL have port irq_src, input, NUM_SRC bits, the raw interrupt requests, already synchronous to clk.
REQ-008 The block SHALL have port src_data, input, NUM_SRC*DATA_W bits, the per-source data words; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-009 The block SHALL have port irq_mask, input, NUM_SRC bits; 1 enables dispatch of the channel.
REQ-010 The block SHALL have port stall_interrupt, input, 1 bit; 1 blocks dispatch because a memory read is in flight in the pipeline.
REQ-011 The block SHALL have port irq_return, input, 1 bit, a 1-cycle pulse from decode on rti or rsi.
REQ-012 The block SHALL have port interrupt, output, 1 bit, a 1-cycle dispatch pulse to fetch.
REQ-013 The block SHALL have port irq_id, output, 4 bits, the index of the channel dispatched last.
REQ-014 The block SHALL have port irq_data, output, DATA_W bits, the src_data word captured at dispatch; it is read by the rdi instruction.
REQ-015 The block SHALL have port in_service, output, 1 bit; 1 means a handler is active.
REQ-016 The block SHALL have port pending, output, NUM_SRC bits, the pending register.
REQ-017 The block SHALL have port overflow, output, NUM_SRC bits, sticky per-channel lost-event flags.

Function
REQ-018 The block SHALL register irq_src into src_prev every cycle; the edge event for a channel is irq_src & ~src_prev, and the level event is irq_src.
REQ-019 On an event, the block SHALL set pending[i] at the next edge, independent of irq_mask.
REQ-020 An event on a channel whose pending[i] is already 1 SHALL set overflow[i].
REQ-021 A dispatch SHALL occur in cycle t when in_service=0, stall_interrupt=0 and (pending & irq_mask) is nonzero in cycle t.
REQ-022 A dispatch SHALL take effect at the next edge: interrupt=1 for exactly one cycle, irq_id=winner, irq_data=src_data[winner] sampled in cycle t, in_service=1, and pending[winner] and overflow[winner] cleared.
REQ-023 With RR_MODE=0, the winner SHALL be the lowest-index eligible channel.
REQ-024 With RR_MODE=1, the search SHALL start at (last winner+1) mod NUM_SRC and wrap to 0; the last-winner pointer resets to NUM_SRC-1.
REQ-025 If an event and the dispatch clear hit the same channel in the same cycle, the set SHALL win: pending[i] stays 1 and overflow[i] is not set.
REQ-026 irq_return SHALL clear in_service at the next edge; no dispatch is evaluated in the same cycle as irq_return, so the earliest new dispatch is one cycle later.
REQ-027 irq_return while in_service=0 SHALL be ignored.
REQ-028 While stall_interrupt=1, pending requests SHALL be held and not lost; dispatch occurs in the first cycle stall_interrupt=0, subject to REQ-021.
REQ-029 Handlers SHALL NOT nest: while in_service=1, no dispatch occurs regardless of priority.
REQ-030 irq_id and irq_data SHALL hold their values until the next dispatch.
REQ-031 A masked pending channel SHALL remain pending and dispatch when it is unmasked.

Reset
REQ-032 When rst_n=0 at an edge, the block SHALL clear interrupt, irq_id, irq_data, in_service, pending, overflow and src_prev to 0, and set the RR pointer to NUM_SRC-1.
REQ-033 Reset asserted while in_service=1 or with requests pending SHALL abort everything; no interrupt pulse occurs in the cycle after reset is released.
REQ-034 A source held high through reset release SHALL count as a rising edge (src_prev=0), producing one pending set.

Verification
REQ-035 Fixed priority: sources 1 and 3 rise together with mask=4'hF, RR_MODE=0 -> interrupt pulses 2 cycles later with irq_id=1; after irq_return, id=3 dispatches 2 cycles after the pulse.
REQ-036 Round-robin: RR_MODE=1, all 4 sources pending, return issued after each dispatch -> dispatch order 0,1,2,3, then wrap to 0.
REQ-037 Stall: pending[2]=1 and stall_interrupt=1 for 5 cycles -> no pulse; the pulse comes one edge after the stall drops, with irq_data = src_data[2] sampled in the cycle the stall dropped.
REQ-038 Overflow: source 0 produces two edges before it is dispatched -> overflow[0]=1; overflow[0] clears on dispatch; the edge coinciding with the dispatch cycle keeps pending[0]=1.
REQ-039 Level and mask: EDGE_MASK bit0=0, src0 held high with mask bit0=0 -> pending[0]=1 with no pulse; unmasking dispatches the next cycle.
REQ-040 Reset mid-service: in_service=1 and pending=4'b0110, then rst_n low for 1 cycle -> all outputs are 0 and no pulse follows.

Source files
------------

// File: rtl/irq_controller.sv
// Interrupt controller: edge/level capture into a pending register, fixed-priority
// or round-robin arbitration, single-level (non-nesting) dispatch to fetch.
module irq_controller #(
  parameter int unsigned        NUM_SRC   = 4,
  parameter int unsigned        DATA_W    = 32,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = '1,
  parameter bit                 RR_MODE   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        irq_src,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        irq_mask,
  input  logic                      stall_interrupt,
  input  logic                      irq_return,
  output logic                      interrupt,
  output logic [3:0]                irq_id,
  output logic [DATA_W-1:0]         irq_data,
  output logic                      in_service,
  output logic [NUM_SRC-1:0]        pending,
  output logic [NUM_SRC-1:0]        overflow
);

  localparam int unsigned        ID_W     = 4;
  localparam int unsigned        BUS_W    = NUM_SRC * DATA_W;
  localparam logic [ID_W-1:0]    PTR_INIT = ID_W'(NUM_SRC - 1);

  logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] overflow_q, overflow_d;
  logic               interrupt_q, interrupt_d;
  logic               in_service_q, in_service_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic [DATA_W-1:0]  irq_data_q, irq_data_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NUM_SRC-1:0] evt_c;
  logic [NUM_SRC-1:0] eligible_c;
  logic [NUM_SRC-1:0] win_clr_c;
  logic [ID_W-1:0]    win_c;
  logic               dispatch_c;
  logic [BUS_W-1:0]   data_sh_c;

  // First eligible channel, scanning from 0 (fixed) or from ptr+1 with wrap (round-robin).
  function automatic logic [ID_W-1:0] pick(input logic [NUM_SRC-1:0] elig,
                                           input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0]    res;
    logic               found;
    int unsigned        idx;
    logic [NUM_SRC-1:0] sh;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = RR_MODE ? ((32'(ptr) + 32'd1 + k) % NUM_SRC) : k;
      sh  = elig >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        res   = ID_W'(idx);
      end
    end
    return res;
  endfunction

  always_comb begin
    src_prev_d   = irq_src;
    pending_d    = pending_q;
    overflow_d   = overflow_q;
    interrupt_d  = 1'b0;
    in_service_d = in_service_q;
    irq_id_d     = irq_id_q;
    irq_data_d   = irq_data_q;
    rr_ptr_d     = rr_ptr_q;

    evt_c      = irq_src & ((EDGE_MASK & ~src_prev_q) | ~EDGE_MASK);
    eligible_c = pending_q & irq_mask;
    dispatch_c = !in_service_q && !stall_interrupt && (|eligible_c);
    win_c      = pick(eligible_c, rr_ptr_q);
    win_clr_c  = dispatch_c ? (NUM_SRC'(1) << win_c) : '0;
    data_sh_c  = src_data >> (32'(win_c) * DATA_W);

    if (irq_return) in_service_d = 1'b0;

    // A new event on the winner in the dispatch cycle re-arms it without flagging overflow.
    overflow_d = (overflow_q | (evt_c & pending_q)) & ~win_clr_c;
    pending_d  = (pending_q & ~win_clr_c) | evt_c;

    if (dispatch_c) begin
      interrupt_d  = 1'b1;
      in_service_d = 1'b1;
      irq_id_d     = win_c;
      irq_data_d   = data_sh_c[DATA_W-1:0];
      rr_ptr_d     = win_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_prev_q   <= '0;
      pending_q    <= '0;
      overflow_q   <= '0;
      interrupt_q  <= 1'b0;
      in_service_q <= 1'b0;
      irq_id_q     <= '0;
      irq_data_q   <= '0;
      rr_ptr_q     <= PTR_INIT;
    end else begin
      src_prev_q   <= src_prev_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      interrupt_q  <= interrupt_d;
      in_service_q <= in_service_d;
      irq_id_q     <= irq_id_d;
      irq_data_q   <= irq_data_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign interrupt  = interrupt_q;
  assign irq_id     = irq_id_q;
  assign irq_data   = irq_data_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: fixed-priority, round-robin and level-triggered instances
// share one stimulus; each scenario checks the instance it targets.
module tb_irq_controller;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   irq_src;
  logic [127:0] src_data;
  logic [3:0]   irq_mask;
  logic         stall_interrupt;
  logic         irq_return;

  logic        fp_int, rr_int, lv_int;
  logic [3:0]  fp_id, rr_id, lv_id;
  logic [31:0] fp_data, rr_data, lv_data;
  logic        fp_svc, rr_svc, lv_svc;
  logic [3:0]  fp_pend, rr_pend, lv_pend;
  logic [3:0]  fp_ovf, rr_ovf, lv_ovf;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [127:0] DATA_INIT = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

  always #5 clk = ~clk;

  irq_controller dut_fp (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .src_data(src_data),
    .irq_mask(irq_mask), .stall_interrupt(stall_interrupt), .irq_return(irq_return),
    .interrupt(fp_int), .irq_id(fp_id), .irq_data(fp_data), .in_service(fp_svc),
    .pending(fp_pend), .overflow(fp_ovf)
  );

  irq_controller #(.RR_MODE(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .src_data(src_data),
    .irq_mask(irq_mask), .stall_interrupt(stall_interrupt), .irq_return(irq_return),
    .interrupt(rr_int), .irq_id(rr_id), .irq_data(rr_data), .in_service(rr_svc),
    .pending(rr_pend), .overflow(rr_ovf)
  );

  irq_controller #(.EDGE_MASK(4'b1110)) dut_lv (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .src_data(src_data),
    .irq_mask(irq_mask), .stall_interrupt(stall_interrupt), .irq_return(irq_return),
    .interrupt(lv_int), .irq_id(lv_id), .irq_data(lv_data), .in_service(lv_svc),
    .pending(lv_pend), .overflow(lv_ovf)
  );

  typedef struct {
    logic [3:0]  src;
    logic [3:0]  mask;
    logic        stall;
    logic        ret;
    logic        exp_int;
    logic [3:0]  exp_id;
    logic [31:0] exp_data;
    logic [3:0]  exp_pend;
    logic        exp_svc;
    logic [3:0]  exp_ovf;
  } vec_t;

  vec_t vec[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Inputs are changed 1 time unit after an edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    irq_src = '0;
    irq_mask = 4'hF;
    stall_interrupt = 1'b0;
    irq_return = 1'b0;
    src_data = DATA_INIT;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Fixed-priority walk: simultaneous sources, return, nesting block, masking, ignored return.
    vec[0]  = '{4'b1010, 4'hF, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,  4'b1010, 1'b0, 4'b0};
    vec[1]  = '{4'b1010, 4'hF, 1'b0, 1'b0, 1'b1, 4'd1, 32'hD1, 4'b1000, 1'b1, 4'b0};
    vec[2]  = '{4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 4'd1, 32'hD1, 4'b1000, 1'b0, 4'b0};
    vec[3]  = '{4'b0000, 4'hF, 1'b0, 1'b0, 1'b1, 4'd3, 32'hD3, 4'b0000, 1'b1, 4'b0};
    vec[4]  = '{4'b0000, 4'hF, 1'b0, 1'b0, 1'b0, 4'd3, 32'hD3, 4'b0000, 1'b1, 4'b0};
    vec[5]  = '{4'b0100, 4'hF, 1'b0, 1'b0, 1'b0, 4'd3, 32'hD3, 4'b0100, 1'b1, 4'b0};
    vec[6]  = '{4'b0100, 4'hF, 1'b0, 1'b0, 1'b0, 4'd3, 32'hD3, 4'b0100, 1'b1, 4'b0};
    vec[7]  = '{4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 4'd3, 32'hD3, 4'b0100, 1'b0, 4'b0};
    vec[8]  = '{4'b0000, 4'hB, 1'b0, 1'b0, 1'b0, 4'd3, 32'hD3, 4'b0100, 1'b0, 4'b0};
    vec[9]  = '{4'b0000, 4'hF, 1'b0, 1'b0, 1'b1, 4'd2, 32'hD2, 4'b0000, 1'b1, 4'b0};
    vec[10] = '{4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 4'd2, 32'hD2, 4'b0000, 1'b0, 4'b0};
    vec[11] = '{4'b0001, 4'hF, 1'b0, 1'b1, 1'b0, 4'd2, 32'hD2, 4'b0001, 1'b0, 4'b0};
    vec[12] = '{4'b0000, 4'hF, 1'b0, 1'b0, 1'b1, 4'd0, 32'hD0, 4'b0000, 1'b1, 4'b0};

    do_reset();
    check("reset_int",  32'(fp_int),  0);
    check("reset_id",   32'(fp_id),   0);
    check("reset_data", fp_data,      0);
    check("reset_svc",  32'(fp_svc),  0);
    check("reset_pend", 32'(fp_pend), 0);
    check("reset_ovf",  32'(fp_ovf),  0);

    for (int i = 0; i < 13; i++) begin
      irq_src = vec[i].src;
      irq_mask = vec[i].mask;
      stall_interrupt = vec[i].stall;
      irq_return = vec[i].ret;
      step();
      check($sformatf("vec%0d_int", i),  32'(fp_int),  32'(vec[i].exp_int));
      check($sformatf("vec%0d_id", i),   32'(fp_id),   32'(vec[i].exp_id));
      check($sformatf("vec%0d_data", i), fp_data,      vec[i].exp_data);
      check($sformatf("vec%0d_pend", i), 32'(fp_pend), 32'(vec[i].exp_pend));
      check($sformatf("vec%0d_svc", i),  32'(fp_svc),  32'(vec[i].exp_svc));
      check($sformatf("vec%0d_ovf", i),  32'(fp_ovf),  32'(vec[i].exp_ovf));
    end
    irq_return = 1'b0;

    // Round-robin: source 0 re-raised after its dispatch must still wait its turn.
    do_reset();
    irq_src = 4'hF;
    step();
    check("rr_pend_all", 32'(rr_pend), 32'hF);
    irq_src = 4'h0;
    step();
    check("rr_first_int", 32'(rr_int), 1);
    check("rr_first_id",  32'(rr_id),  0);
    for (int k = 1; k <= 4; k++) begin
      logic [3:0] exp_ids;
      exp_ids = 4'b0;
      irq_return = 1'b1;
      irq_src = (k == 1) ? 4'b0001 : 4'b0000;
      step();
      irq_return = 1'b0;
      irq_src = 4'b0000;
      step();
      case (k)
        1: exp_ids = 4'd1;
        2: exp_ids = 4'd2;
        3: exp_ids = 4'd3;
        default: exp_ids = 4'd0;
      endcase
      check($sformatf("rr_int_%0d", k), 32'(rr_int), 1);
      check($sformatf("rr_id_%0d", k),  32'(rr_id),  32'(exp_ids));
    end

    // Stall: request held for 5 cycles, data sampled in the cycle the stall drops.
    do_reset();
    irq_src = 4'b0100;
    step();
    irq_src = 4'b0000;
    stall_interrupt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("stall_noint_%0d", k), 32'(fp_int), 0);
    end
    check("stall_pend_held", 32'(fp_pend), 32'b0100);
    stall_interrupt = 1'b0;
    src_data[95:64] = 32'h5555_0002;
    step();
    src_data = DATA_INIT;
    check("stall_int",  32'(fp_int), 1);
    check("stall_id",   32'(fp_id),  2);
    check("stall_data", fp_data,     32'h5555_0002);

    // Overflow: two edges while masked, third edge coinciding with the dispatch cycle.
    do_reset();
    irq_mask = 4'b1110;
    irq_src = 4'b0001; step();
    irq_src = 4'b0000; step();
    irq_src = 4'b0001; step();
    check("ovf_set",  32'(fp_ovf),  32'b0001);
    check("ovf_pend", 32'(fp_pend), 32'b0001);
    irq_src = 4'b0000; step();
    irq_mask = 4'hF;
    irq_src = 4'b0001; step();
    check("ovf_disp_int",  32'(fp_int),  1);
    check("ovf_disp_id",   32'(fp_id),   0);
    check("ovf_cleared",   32'(fp_ovf),  0);
    check("ovf_pend_kept", 32'(fp_pend), 32'b0001);
    irq_src = 4'b0000;

    // Level source: masked stays pending with no pulse, unmasking dispatches next cycle.
    do_reset();
    irq_mask = 4'b1110;
    irq_src = 4'b0001;
    step();
    check("lvl_pend",   32'(lv_pend), 32'b0001);
    check("lvl_noint0", 32'(lv_int),  0);
    step();
    check("lvl_noint1", 32'(lv_int),  0);
    irq_mask = 4'hF;
    step();
    check("lvl_int", 32'(lv_int), 1);
    check("lvl_id",  32'(lv_id),  0);
    irq_src = 4'b0000;

    // Reset mid-service with requests pending aborts everything.
    do_reset();
    irq_src = 4'b0001; step();
    irq_src = 4'b0000; step();
    irq_src = 4'b0110; step();
    check("rst_mid_svc",  32'(fp_svc),  1);
    check("rst_mid_pend", 32'(fp_pend), 32'b0110);
    rst_n = 1'b0;
    step();
    check("rst_abort_int",  32'(fp_int),  0);
    check("rst_abort_id",   32'(fp_id),   0);
    check("rst_abort_data", fp_data,      0);
    check("rst_abort_svc",  32'(fp_svc),  0);
    check("rst_abort_pend", 32'(fp_pend), 0);
    check("rst_abort_ovf",  32'(fp_ovf),  0);
    rst_n = 1'b1;
    irq_src = 4'b0000;
    step();
    check("rst_after_int0", 32'(fp_int), 0);
    step();
    check("rst_after_int1", 32'(fp_int), 0);

    // Source held high through reset release counts as one rising edge.
    rst_n = 1'b0;
    irq_src = 4'b1000;
    step();
    rst_n = 1'b1;
    step();
    check("rst_held_noint", 32'(fp_int),  0);
    check("rst_held_pend",  32'(fp_pend), 32'b1000);
    step();
    check("rst_held_int", 32'(fp_int),  1);
    check("rst_held_id",  32'(fp_id),   3);
    check("rst_held_pend_clr", 32'(fp_pend), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
